demux_1n_reg: RTL and testbench

Parametrised, registered 1-to-N demultiplexer with a valid/ready handshake on every port. It replaces the fixed combinational 1:4 demux tree wherever a routed word must be held until its consumer accepts it. Each output channel has a one-entry holding register. A broadcast mode delivers one input word to all channels at once, and out-of-range selects are dropped and counted.

---
 rtl/demux_1n_reg_if.sv | 26 ++
 rtl/demux_1n_reg.sv | 93 +++++++++
 tb/tb_demux_1n_reg.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/demux_1n_reg_if.sv
// Handshake bundle for the registered 1-to-N demultiplexer: one input port
// and NUM_OUT output channels, each with valid/ready.
interface demux_1n_reg_if #(
    parameter int WIDTH   = 16,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         in_data;
    logic [SEL_W-1:0]         in_sel;
    logic                     in_bcast;
    logic [NUM_OUT-1:0]       out_valid;
    logic [NUM_OUT-1:0]       out_ready;
    logic [NUM_OUT*WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/demux_1n_reg.sv
// Registered 1-to-N demultiplexer: one holding register per channel, broadcast
// delivery to all channels, out-of-range selects dropped and counted.
module demux_1n_reg #(
    parameter int WIDTH   = 16,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    demux_1n_reg_if.slave    bus,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             busy
);
    logic [NUM_OUT-1:0]       w_free;
    logic [NUM_OUT-1:0]       w_hit;
    logic [NUM_OUT-1:0]       w_load;
    logic [NUM_OUT-1:0]       w_valid_nxt;
    logic                     w_in_range;
    logic                     w_ready;
    logic                     w_xfer;
    logic                     w_drop;

    logic [NUM_OUT-1:0]       r_valid;
    logic [NUM_OUT*WIDTH-1:0] r_data;
    logic [CNT_W-1:0]         r_drop;
    logic                     r_busy;

    // Acceptance decision, per-channel load strobes and next occupancy.
    always_comb begin
        w_free = ~r_valid | bus.out_ready;
        w_hit  = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            w_hit[i] = (bus.in_sel == SEL_W'(i));
        end
        w_in_range = |w_hit;

        // Out-of-range words are always taken so they can be discarded.
        if (rst) begin
            w_ready = 1'b0;
        end else if (bus.in_bcast) begin
            w_ready = &w_free;
        end else if (w_in_range) begin
            w_ready = |(w_hit & w_free);
        end else begin
            w_ready = 1'b1;
        end

        w_xfer = bus.in_valid && w_ready;
        w_drop = w_xfer && !bus.in_bcast && !w_in_range;

        if (w_xfer && bus.in_bcast) begin
            w_load = '1;
        end else if (w_xfer) begin
            w_load = w_hit;
        end else begin
            w_load = '0;
        end

        w_valid_nxt = (r_valid & ~bus.out_ready) | w_load;
    end

    // Holding registers, saturating drop counter and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_data  <= '0;
            r_drop  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= w_valid_nxt;
            r_busy  <= |w_valid_nxt;
            for (int i = 0; i < NUM_OUT; i++) begin
                if (w_load[i]) begin
                    r_data[i*WIDTH +: WIDTH] <= bus.in_data;
                end else begin
                    r_data[i*WIDTH +: WIDTH] <= r_data[i*WIDTH +: WIDTH];
                end
            end
            if (w_drop && (r_drop != '1)) begin
                r_drop <= r_drop + CNT_W'(1);
            end else begin
                r_drop <= r_drop;
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign drop_cnt      = r_drop;
    assign busy          = r_busy;
endmodule

// File: tb/tb_demux_1n_reg.sv
// Bench for demux_1n_reg: a 4-channel instance and a 3-channel, 2-bit-counter
// instance, checked against a per-channel occupancy model.
module tb_demux_1n_reg;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [7:0] drop_a;
    logic [1:0] drop_b;
    logic       busy_a, busy_b;

    demux_1n_reg_if #(.WIDTH(16), .NUM_OUT(4), .SEL_W(2)) bus_a ();
    demux_1n_reg_if #(.WIDTH(16), .NUM_OUT(3), .SEL_W(2)) bus_b ();

    demux_1n_reg #(.WIDTH(16), .NUM_OUT(4), .SEL_W(2), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst_a), .bus(bus_a), .drop_cnt(drop_a), .busy(busy_a)
    );
    demux_1n_reg #(.WIDTH(16), .NUM_OUT(3), .SEL_W(2), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst_b), .bus(bus_b), .drop_cnt(drop_b), .busy(busy_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference model: which channels hold a word, and what word
    bit          m_full [2][4];
    logic [15:0] m_dat  [2][4];
    int          m_drop [2];

    // inputs currently applied to each unit
    bit          c_v   [2];
    logic [15:0] c_d   [2];
    logic [1:0]  c_s   [2];
    bit          c_b   [2];
    logic [3:0]  c_r   [2];
    bit          c_rst [2];

    function automatic int n_of(int u);
        return (u == 0) ? 4 : 3;
    endfunction

    function automatic int cmax(int u);
        return (u == 0) ? 255 : 3;
    endfunction

    function automatic bit exp_ready(int u);
        if (c_rst[u]) return 1'b0;
        if (c_b[u]) begin
            for (int i = 0; i < n_of(u); i++)
                if (m_full[u][i] && !c_r[u][i]) return 1'b0;
            return 1'b1;
        end
        if (int'(c_s[u]) < n_of(u)) return !m_full[u][c_s[u]] || c_r[u][c_s[u]];
        return 1'b1;
    endfunction

    function automatic logic [3:0] exp_valid(int u);
        logic [3:0] v;
        v = 4'h0;
        for (int i = 0; i < n_of(u); i++) v[i] = m_full[u][i];
        return v;
    endfunction

    function logic [3:0] get_valid(int u);
        return (u == 0) ? bus_a.out_valid : {1'b0, bus_b.out_valid};
    endfunction

    function logic [15:0] get_data(int u, int i);
        return (u == 0) ? bus_a.out_data[i*16 +: 16] : bus_b.out_data[i*16 +: 16];
    endfunction

    function logic get_ready(int u);
        return (u == 0) ? bus_a.in_ready : bus_b.in_ready;
    endfunction

    function logic [7:0] get_drop(int u);
        return (u == 0) ? drop_a : {6'd0, drop_b};
    endfunction

    function logic get_busy(int u);
        return (u == 0) ? busy_a : busy_b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_inputs();
        bus_a.in_valid  = c_v[0];
        bus_a.in_data   = c_d[0];
        bus_a.in_sel    = c_s[0];
        bus_a.in_bcast  = c_b[0];
        bus_a.out_ready = c_r[0];
        rst_a           = c_rst[0];
        bus_b.in_valid  = c_v[1];
        bus_b.in_data   = c_d[1];
        bus_b.in_sel    = c_s[1];
        bus_b.in_bcast  = c_b[1];
        bus_b.out_ready = c_r[1][2:0];
        rst_b           = c_rst[1];
    endtask

    // One clock: unit u gets the given inputs, the other unit idles.
    task automatic run_cycle(input int u, input bit v, input logic [15:0] d, input logic [1:0] s,
                             input bit b, input logic [3:0] r, input bit rs);
        bit xf [2];
        for (int k = 0; k < 2; k++) begin
            c_v[k]   = (k == u) ? v  : 1'b0;
            c_d[k]   = (k == u) ? d  : 16'h0000;
            c_s[k]   = (k == u) ? s  : 2'd0;
            c_b[k]   = (k == u) ? b  : 1'b0;
            c_r[k]   = (k == u) ? r  : 4'hF;
            c_rst[k] = (k == u) ? rs : 1'b0;
        end
        apply_inputs();
        #1;
        chk("in_ready", get_ready(u), exp_ready(u));
        for (int k = 0; k < 2; k++) xf[k] = c_v[k] && exp_ready(k);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < n_of(k); i++) begin
                if (c_rst[k]) begin
                    m_full[k][i] = 1'b0;
                    m_dat[k][i]  = 16'h0000;
                end else begin
                    if (m_full[k][i] && c_r[k][i]) m_full[k][i] = 1'b0;
                    if (xf[k] && (c_b[k] || int'(c_s[k]) == i)) begin
                        m_full[k][i] = 1'b1;
                        m_dat[k][i]  = c_d[k];
                    end
                end
            end
            if (c_rst[k]) m_drop[k] = 0;
            else if (xf[k] && !c_b[k] && int'(c_s[k]) >= n_of(k) && m_drop[k] < cmax(k))
                m_drop[k] = m_drop[k] + 1;
        end
        @(posedge clk);
        #1;
        chk("out_valid", get_valid(u), exp_valid(u));
        for (int i = 0; i < n_of(u); i++)
            if (m_full[u][i]) chk("out_data", get_data(u, i), m_dat[u][i]);
        chk("drop_cnt", get_drop(u), m_drop[u]);
        chk("busy", get_busy(u), |exp_valid(u));
    endtask

    initial begin
        // both units held in reset for one edge before the checked reset cycles
        for (int k = 0; k < 2; k++) begin
            c_v[k] = 1'b1; c_d[k] = 16'h1234; c_s[k] = 2'd0; c_b[k] = 1'b0;
            c_r[k] = 4'hF; c_rst[k] = 1'b1; m_drop[k] = 0;
            for (int i = 0; i < 4; i++) begin
                m_full[k][i] = 1'b0;
                m_dat[k][i]  = 16'h0000;
            end
        end
        apply_inputs();
        @(posedge clk);
        #1;

        // reset with in_valid held high
        run_cycle(0, 1'b1, 16'h1234, 2'd1, 1'b0, 4'hF, 1'b1);
        run_cycle(0, 1'b1, 16'h1234, 2'd2, 1'b1, 4'hF, 1'b1);
        chk("rst_in_ready", bus_a.in_ready, 1'b0);
        chk("rst_out_data", bus_a.out_data, 64'd0);
        run_cycle(1, 1'b1, 16'h1234, 2'd3, 1'b0, 4'hF, 1'b1);
        chk("rst_out_data_b", bus_b.out_data, 48'd0);

        // after release every select is accepted
        for (int s = 0; s < 4; s++) begin
            run_cycle(0, 1'b0, 16'h0000, 2'(s), 1'b0, 4'hF, 1'b0);
            chk("idle_ready", bus_a.in_ready, 1'b1);
        end

        // routed back-to-back with all consumers ready
        for (int i = 0; i < 4; i++) begin
            run_cycle(0, 1'b1, 16'hA001 + 16'(i), 2'(i), 1'b0, 4'hF, 1'b0);
            chk("routed_valid", bus_a.out_valid, 4'b0001 << i);
            chk("routed_data", bus_a.out_data[i*16 +: 16], 16'hA001 + 16'(i));
        end
        run_cycle(0, 1'b0, 16'h0000, 2'd0, 1'b0, 4'hF, 1'b0);

        // channel 2 stalled
        run_cycle(0, 1'b1, 16'hBEEF, 2'd2, 1'b0, 4'hB, 1'b0);
        run_cycle(0, 1'b1, 16'hCAFE, 2'd2, 1'b0, 4'hB, 1'b0);
        chk("bp_blocked", bus_a.in_ready, 1'b0);
        chk("bp_hold", bus_a.out_data[32 +: 16], 16'hBEEF);
        run_cycle(0, 1'b1, 16'h1111, 2'd1, 1'b0, 4'hB, 1'b0);
        chk("bp_other_ch", bus_a.out_valid, 4'b0110);
        run_cycle(0, 1'b1, 16'hCAFE, 2'd2, 1'b0, 4'hF, 1'b0);
        chk("bp_refill", bus_a.out_data[32 +: 16], 16'hCAFE);
        chk("bp_refill_v", bus_a.out_valid, 4'b0100);
        run_cycle(0, 1'b0, 16'h0000, 2'd0, 1'b0, 4'hF, 1'b0);

        // broadcast waits for stalled channel 3
        run_cycle(0, 1'b1, 16'h3333, 2'd3, 1'b0, 4'h7, 1'b0);
        for (int k = 0; k < 2; k++) begin
            run_cycle(0, 1'b1, 16'h5A5A, 2'd0, 1'b1, 4'h7, 1'b0);
            chk("bc_wait", bus_a.in_ready, 1'b0);
        end
        run_cycle(0, 1'b1, 16'h5A5A, 2'd0, 1'b1, 4'hF, 1'b0);
        chk("bc_all_valid", bus_a.out_valid, 4'hF);
        for (int i = 0; i < 4; i++) chk("bc_data", bus_a.out_data[i*16 +: 16], 16'h5A5A);
        run_cycle(0, 1'b0, 16'h0000, 2'd0, 1'b0, 4'hF, 1'b0);

        // out-of-range drops on the 3-channel unit, counter saturating at 3
        for (int k = 0; k < 5; k++) begin
            run_cycle(1, 1'b1, 16'hD000 + 16'(k), 2'd3, 1'b0, 4'h7, 1'b0);
            chk("drop_cnt_seq", drop_b, (k < 3) ? 2'(k + 1) : 2'd3);
            chk("drop_no_valid", bus_b.out_valid, 3'b000);
            chk("drop_ready", bus_b.in_ready, 1'b1);
        end

        // reset with every channel full
        run_cycle(0, 1'b1, 16'h7777, 2'd0, 1'b1, 4'h0, 1'b0);
        chk("mid_full", bus_a.out_valid, 4'hF);
        run_cycle(0, 1'b0, 16'h0000, 2'd0, 1'b0, 4'h0, 1'b1);
        chk("mid_rst_valid", bus_a.out_valid, 4'h0);
        run_cycle(0, 1'b1, 16'h8888, 2'd1, 1'b0, 4'hF, 1'b0);
        chk("mid_resume", bus_a.out_data[16 +: 16], 16'h8888);

        // randomized traffic on both units
        for (int k = 0; k < 400; k++) begin
            run_cycle(int'($urandom_range(0, 1)), 1'($urandom), 16'($urandom), 2'($urandom),
                      ($urandom_range(0, 7) == 0), 4'($urandom), ($urandom_range(0, 63) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
